// File: rtl/cpu_jtag_debug_scan_master_if.sv
// Command/response handshake bundle between a scan requester (master) and
// cpu_jtag_debug_scan_master (slave).
interface cpu_jtag_debug_scan_master_if #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [DR_WIDTH-1:0] cmd_dr;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DR_WIDTH-1:0] rsp_dr;
    logic [IR_WIDTH-1:0] rsp_ir_out;

    modport master (
        output cmd_valid, cmd_ir, cmd_dr, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_dr, rsp_ir_out
    );

    modport slave (
        input  cmd_valid, cmd_ir, cmd_dr, rsp_ready,
        output cmd_ready, rsp_valid, rsp_dr, rsp_ir_out
    );
endinterface

// File: rtl/cpu_jtag_debug_scan_master.sv
// Host-side virtual-JTAG scan driver: UIR -> CDR -> SDR x DR_WIDTH -> UDR per command.
// Optional feature macro SCAN_SKIP_IR_EN: skip UIR when the IR matches the last loaded one.
module cpu_jtag_debug_scan_master #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    cpu_jtag_debug_scan_master_if.slave  bus,
    output logic                         tck,
    output logic                         tdi,
    input  logic                         tdo,
    output logic [IR_WIDTH-1:0]          ir_in,
    input  logic [IR_WIDTH-1:0]          ir_out,
    output logic                         vs_uir,
    output logic                         vs_cdr,
    output logic                         vs_sdr,
    output logic                         vs_udr,
    output logic                         jtag_state_rti
);
    localparam int               CNT_W     = $clog2(2 * TCK_DIV);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(TCK_DIV - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(2 * TCK_DIV - 1);
    localparam logic [5:0]       BITS      = 6'(DR_WIDTH);

    // S_FIN is the single cycle between the end of UDR and rsp_valid rising.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_UIR  = 3'd1,
        S_CDR  = 3'd2,
        S_SDR  = 3'd3,
        S_UDR  = 3'd4,
        S_FIN  = 3'd5,
        S_RSP  = 3'd6
    } state_t;

    state_t              state_r;
    logic [CNT_W-1:0]    div_cnt_r;
    logic [5:0]          bit_cnt_r;
    logic [DR_WIDTH-1:0] sr_r;
    logic                rsp_valid_r;
    logic [DR_WIDTH-1:0] rsp_dr_r;
    logic [IR_WIDTH-1:0] rsp_ir_out_r;
    logic                rise_s;
    logic                phase_end_s;
    logic                skip_uir_s;

    assign rise_s         = (div_cnt_r == HALF_LAST);
    assign phase_end_s    = (div_cnt_r == FULL_LAST);
    assign bus.cmd_ready  = (state_r == S_IDLE) && !reset;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_dr     = rsp_dr_r;
    assign bus.rsp_ir_out = rsp_ir_out_r;

`ifdef SCAN_SKIP_IR_EN
    logic [IR_WIDTH-1:0] last_ir_r;
    logic                last_ir_valid_r;

    assign skip_uir_s = last_ir_valid_r && (bus.cmd_ir == last_ir_r);

    // Remember the IR of the most recently accepted command.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_ir_r       <= {IR_WIDTH{1'b0}};
            last_ir_valid_r <= 1'b0;
        end else if ((state_r == S_IDLE) && bus.cmd_valid) begin
            last_ir_r       <= bus.cmd_ir;
            last_ir_valid_r <= 1'b1;
        end else begin
            last_ir_r       <= last_ir_r;
            last_ir_valid_r <= last_ir_valid_r;
        end
    end
`else
    assign skip_uir_s = 1'b0;
`endif

    // Scan sequencer: TCK generation, virtual-state strobes, shift register and response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= S_IDLE;
            div_cnt_r      <= {CNT_W{1'b0}};
            bit_cnt_r      <= 6'd0;
            sr_r           <= {DR_WIDTH{1'b0}};
            tck            <= 1'b0;
            tdi            <= 1'b0;
            ir_in          <= {IR_WIDTH{1'b0}};
            vs_uir         <= 1'b0;
            vs_cdr         <= 1'b0;
            vs_sdr         <= 1'b0;
            vs_udr         <= 1'b0;
            jtag_state_rti <= 1'b1;
            rsp_valid_r    <= 1'b0;
            rsp_dr_r       <= {DR_WIDTH{1'b0}};
            rsp_ir_out_r   <= {IR_WIDTH{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        ir_in          <= bus.cmd_ir;
                        sr_r           <= bus.cmd_dr;
                        div_cnt_r      <= {CNT_W{1'b0}};
                        bit_cnt_r      <= 6'd0;
                        tck            <= 1'b0;
                        jtag_state_rti <= 1'b0;
                        if (skip_uir_s) begin
                            state_r <= S_CDR;
                            vs_cdr  <= 1'b1;
                            tdi     <= bus.cmd_dr[0];
                        end else begin
                            state_r <= S_UIR;
                            vs_uir  <= 1'b1;
                            tdi     <= 1'b0;
                        end
                    end else begin
                        jtag_state_rti <= 1'b1;
                    end
                end

                S_UIR, S_CDR, S_SDR, S_UDR: begin
                    if (phase_end_s) begin
                        // Falling TCK edge: the only place the scan state advances.
                        div_cnt_r <= {CNT_W{1'b0}};
                        tck       <= 1'b0;
                        case (state_r)
                            S_UIR: begin
                                state_r <= S_CDR;
                                vs_uir  <= 1'b0;
                                vs_cdr  <= 1'b1;
                                tdi     <= sr_r[0];
                            end
                            S_CDR: begin
                                state_r <= S_SDR;
                                vs_cdr  <= 1'b0;
                                vs_sdr  <= 1'b1;
                                tdi     <= sr_r[0];
                            end
                            S_SDR: begin
                                if (bit_cnt_r == BITS) begin
                                    state_r <= S_UDR;
                                    vs_sdr  <= 1'b0;
                                    vs_udr  <= 1'b1;
                                    tdi     <= 1'b0;
                                end else begin
                                    tdi <= sr_r[0];
                                end
                            end
                            S_UDR: begin
                                state_r <= S_FIN;
                                vs_udr  <= 1'b0;
                            end
                            default: begin
                                state_r <= S_IDLE;
                            end
                        endcase
                    end else begin
                        div_cnt_r <= div_cnt_r + CNT_W'(1);
                        if (rise_s) begin
                            tck <= 1'b1;
                            case (state_r)
                                S_UIR: rsp_ir_out_r <= ir_out;
                                S_SDR: begin
                                    sr_r      <= {tdo, sr_r[DR_WIDTH-1:1]};
                                    bit_cnt_r <= bit_cnt_r + 6'd1;
                                end
                                default: sr_r <= sr_r;
                            endcase
                        end else begin
                            tck <= tck;
                        end
                    end
                end

                S_FIN: begin
                    rsp_dr_r    <= sr_r;
                    rsp_valid_r <= 1'b1;
                    state_r     <= S_RSP;
                end

                S_RSP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r    <= 1'b0;
                        state_r        <= S_IDLE;
                        jtag_state_rti <= 1'b1;
                    end else begin
                        rsp_valid_r <= 1'b1;
                    end
                end

                default: begin
                    state_r        <= S_IDLE;
                    tck            <= 1'b0;
                    tdi            <= 1'b0;
                    vs_uir         <= 1'b0;
                    vs_cdr         <= 1'b0;
                    vs_sdr         <= 1'b0;
                    vs_udr         <= 1'b0;
                    rsp_valid_r    <= 1'b0;
                    jtag_state_rti <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_jtag_debug_scan_master.sv
// Randomized self-checking bench for cpu_jtag_debug_scan_master against a cycle-offset
// behavioural model (phase = offset / TCK period).
module tb_cpu_jtag_debug_scan_master;
    localparam int W    = 38;
    localparam int IRW  = 2;
    localparam int D    = 4;
    localparam int LOGN = 2 * D * (W + 3) + 2;

    logic           clk;
    logic           reset;
    logic           tck, tdi, tdo, tdo_rnd;
    logic [IRW-1:0] ir_in, ir_out;
    logic           vs_uir, vs_cdr, vs_sdr, vs_udr, rti;
    int             mode;
    logic           chk_en;
    int             n_checks, n_errors;

    cpu_jtag_debug_scan_master_if #(.DR_WIDTH(W), .IR_WIDTH(IRW)) bus ();

    cpu_jtag_debug_scan_master #(.DR_WIDTH(W), .IR_WIDTH(IRW), .TCK_DIV(D)) dut (
        .clk(clk), .reset(reset), .bus(bus), .tck(tck), .tdi(tdi), .tdo(tdo),
        .ir_in(ir_in), .ir_out(ir_out), .vs_uir(vs_uir), .vs_cdr(vs_cdr),
        .vs_sdr(vs_sdr), .vs_udr(vs_udr), .jtag_state_rti(rti)
    );

    // tdo source: 0 loopback, 1 tied low, 2 tied high, 3 random every cycle
    assign tdo = (mode == 0) ? tdi : (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : tdo_rnd;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        tdo_rnd = 1'b0;
        forever begin
            @(negedge clk);
            tdo_rnd = 1'($urandom);
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic           m_busy, m_rspv, m_skip, m_last_valid;
    int             m_j, m_mode;
    logic [IRW-1:0] m_ir, m_irs, m_rsp_ir, m_last_ir;
    logic [W-1:0]   m_dr, m_rsp_dr;
    logic           tdo_log [0:LOGN-1];

    function automatic int m_total(input logic skip);
        return 2 * D * (W + (skip ? 2 : 3));
    endfunction

    function automatic logic [W-1:0] exp_dr();
        logic [W-1:0] r;
        case (m_mode)
            0:       r = m_dr;
            1:       r = '0;
            2:       r = '1;
            default: for (int b = 0; b < W; b++) r[b] = tdo_log[2 * D * ((m_skip ? 1 : 2) + b) + D];
        endcase
        return r;
    endfunction

    // {tck, tdi, vs_uir, vs_cdr, vs_sdr, vs_udr} at offset k cycles after the accept edge
    function automatic logic [5:0] exp_scan(input logic busy, input int k, input logic skip,
                                            input logic [W-1:0] dr);
        int q;
        logic t, d;
        logic [3:0] vs;
        exp_scan = 6'b0;
        if (busy && k < m_total(skip)) begin
            q  = k / (2 * D) + (skip ? 1 : 0);
            t  = (k % (2 * D)) >= D;
            d  = 1'b0;
            vs = 4'b0001;
            if (q == 0) vs = 4'b1000;
            else if (q == 1) begin vs = 4'b0100; d = dr[0]; end
            else if (q <= W + 1) begin vs = 4'b0010; d = dr[q-2]; end
            exp_scan = {t, d, vs};
        end
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0; m_rspv <= 1'b0; m_skip <= 1'b0; m_j <= 0; m_ir <= '0; m_dr <= '0;
            m_rsp_dr <= '0; m_rsp_ir <= '0; m_irs <= '0; m_last_valid <= 1'b0; m_last_ir <= '0;
        end else if (!m_busy && !m_rspv) begin
            if (bus.cmd_valid) begin
                m_busy <= 1'b1; m_j <= 0; m_ir <= bus.cmd_ir; m_dr <= bus.cmd_dr; m_mode <= mode;
`ifdef SCAN_SKIP_IR_EN
                m_skip       <= m_last_valid && (bus.cmd_ir == m_last_ir);
                m_last_valid <= 1'b1;
                m_last_ir    <= bus.cmd_ir;
`else
                m_skip <= 1'b0;
`endif
            end
        end else if (m_busy) begin
            if (m_j + 1 < LOGN) tdo_log[m_j+1] <= tdo;
            if (!m_skip && (m_j + 1 == D)) m_irs <= ir_out;
            if (m_j == m_total(m_skip)) begin
                m_busy   <= 1'b0;
                m_rspv   <= 1'b1;
                m_rsp_dr <= exp_dr();
                m_rsp_ir <= m_skip ? m_rsp_ir : m_irs;
            end else begin
                m_j <= m_j + 1;
            end
        end else if (bus.rsp_ready) begin
            m_rspv <= 1'b0;
        end
    end

    // Compare every output against the model on each falling clock edge.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [5:0] e;
            e = exp_scan(m_busy, m_j, m_skip, m_dr);
            check("tck", 64'(tck), 64'(e[5]));
            check("tdi", 64'(tdi), 64'(e[4]));
            check("vstate", 64'({vs_uir, vs_cdr, vs_sdr, vs_udr}), 64'(e[3:0]));
            check("ir_in", 64'(ir_in), 64'(m_ir));
            check("rti", 64'(rti), 64'(!m_busy && !m_rspv));
            check("cmd_ready", 64'(bus.cmd_ready), 64'(!m_busy && !m_rspv && !reset));
            check("rsp_valid", 64'(bus.rsp_valid), 64'(m_rspv));
            if (m_rspv) begin
                check("rsp_dr", 64'(bus.rsp_dr), 64'(m_rsp_dr));
                check("rsp_ir_out", 64'(bus.rsp_ir_out), 64'(m_rsp_ir));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_cmd(input logic [IRW-1:0] ir, input logic [W-1:0] dr, input int md,
                           input logic [IRW-1:0] iro, input int hold, input int lit_lat,
                           input int lit_uir, input logic lit_en, input logic [W-1:0] lit_dr);
        int lat, n_uir, n_cdr, n_udr, n_rise;
        logic prev_tck, got;
        logic [W-1:0] held;
        logic [63:0] r64;
        mode = md; ir_out = iro;
        bus.cmd_ir = ir; bus.cmd_dr = dr; bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        lat = 0; n_uir = 0; n_cdr = 0; n_udr = 0; n_rise = 0; prev_tck = 1'b0; got = 1'b0;
        while (!got && lat < 2000) begin
            if (vs_uir) n_uir++;
            if (vs_cdr) n_cdr++;
            if (vs_udr) n_udr++;
            if (vs_sdr && tck && !prev_tck) n_rise++;
            prev_tck = tck;
            if (bus.rsp_valid) begin
                got = 1'b1;
                bus.cmd_valid = 1'b0;
            end else begin
                // ignored traffic while the scan is busy
                r64 = {$urandom, $urandom};
                bus.cmd_valid = 1'($urandom);
                bus.cmd_ir = r64[IRW-1:0];
                bus.cmd_dr = r64[W-1:0];
                @(posedge clk); #1;
                lat++;
            end
        end
        check("rsp_arrived", 64'(got), 64'(1));
        check("latency", 64'(lat), 64'(m_total(m_skip) + 1));
        check("cdr_cycles", 64'(n_cdr), 64'(8));
        check("udr_cycles", 64'(n_udr), 64'(8));
        check("sdr_tck_rises", 64'(n_rise), 64'(38));
        if (lit_lat != 0) check("latency_lit", 64'(lat), 64'(lit_lat));
        if (lit_uir >= 0) check("uir_cycles", 64'(n_uir), 64'(lit_uir));
        if (lit_en) check("rsp_dr_lit", 64'(bus.rsp_dr), 64'(lit_dr));
        held = bus.rsp_dr;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_valid", 64'(bus.rsp_valid), 64'(1));
            check("hold_dr", 64'(bus.rsp_dr), 64'(held));
            check("hold_ready", 64'(bus.cmd_ready), 64'(0));
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check("ready_after_rsp", 64'(bus.cmd_ready), 64'(1));
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] r;
        int nv;
        chk_en = 1'b0; n_checks = 0; n_errors = 0; mode = 0; ir_out = '0; reset = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_ir = '0; bus.cmd_dr = '0; bus.rsp_ready = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tck", 64'(tck), 64'(0));
        check("rst_rti", 64'(rti), 64'(1));
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'(0));
        check("rst_rsp_dr", 64'(bus.rsp_dr), 64'(0));
        check("rst_rsp_ir_out", 64'(bus.rsp_ir_out), 64'(0));
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // reset for 3 cycles while idle
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_rst_vs", 64'({vs_uir, vs_cdr, vs_sdr, vs_udr, tck}), 64'(0));
        check("idle_rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        reset = 1'b0;
        @(posedge clk); #1;
        check("release_cmd_ready", 64'(bus.cmd_ready), 64'(1));

        // loopback, ir_out readback, pinned latency and strobe counts
        run_cmd(2'b01, 38'h2A5A5AA5A5, 0, 2'b10, 0, 329, 8, 1'b1, 38'h2A5A5AA5A5);
        check("rsp_ir_out_lit", 64'(bus.rsp_ir_out), 64'(2'b10));
        run_cmd(2'b01, 38'h0123456789, 2, 2'b01, 0, 0, -1, 1'b1, 38'h3FFFFFFFFF);
        run_cmd(2'b10, 38'h3FFFFFFFFF, 1, 2'b11, 0, 0, -1, 1'b1, 38'h0);
        run_cmd(2'b00, 38'h155555AAAA, 0, 2'b00, 20, 0, -1, 1'b1, 38'h155555AAAA);

        for (int i = 0; i < 12; i++) begin
            r = {$urandom, $urandom};
            run_cmd(r[IRW-1:0], r[W-1:0], $urandom_range(0, 3), 2'($urandom), $urandom_range(0, 5),
                    0, -1, 1'b0, '0);
        end

        // reset during SDR bit 10: scan dropped, no response
        mode = 0;
        bus.cmd_ir = 2'b10; bus.cmd_dr = 38'h1234567890; bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        check("pre_rst_sdr", 64'(vs_sdr), 64'(1));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_rst_vs_sdr", 64'(vs_sdr), 64'(0));
        check("mid_rst_tck", 64'(tck), 64'(0));
        check("mid_rst_rti", 64'(rti), 64'(1));
        nv = 0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) nv++;
        end
        check("no_rsp_after_rst", 64'(nv), 64'(0));

`ifdef SCAN_SKIP_IR_EN
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        run_cmd(2'b11, 38'h0F0F0F0F0F, 0, 2'b01, 0, 329, 8, 1'b1, 38'h0F0F0F0F0F);
        run_cmd(2'b11, 38'h30F0F0F0F0, 0, 2'b10, 0, 321, 0, 1'b1, 38'h30F0F0F0F0);
        check("skip_keeps_ir_out", 64'(bus.rsp_ir_out), 64'(2'b01));
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
